// File: rtl/idli_dout_buf_m_if.sv
`default_nettype none
// ============================================================================
//  Module      : idli_dout_buf_m_if
//  Description : Handshake bundle for the nibble output buffer. Covers the
//                core-side push handshake, pin-side pop handshake, flush
//                control and the level/framing status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface idli_dout_buf_m_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  // Core side
  logic [3:0]    i_dbuf_din;
  logic          i_dbuf_din_vld;
  logic          o_dbuf_din_acp;
  // Pin side
  logic [3:0]    o_dbuf_dout;
  logic          o_dbuf_dout_vld;
  logic          i_dbuf_dout_acp;
  // Control / status
  logic          i_dbuf_flush;
  logic [LW-1:0] o_dbuf_level;
  logic          o_dbuf_word_pend;
  logic          o_dbuf_word_done;

  // Environment view: drives core nibbles, pin accept and flush
  modport master (
    output i_dbuf_din, i_dbuf_din_vld, i_dbuf_dout_acp, i_dbuf_flush,
    input  o_dbuf_din_acp, o_dbuf_dout, o_dbuf_dout_vld, o_dbuf_level,
           o_dbuf_word_pend, o_dbuf_word_done
  );

  // Buffer view
  modport slave (
    input  i_dbuf_din, i_dbuf_din_vld, i_dbuf_dout_acp, i_dbuf_flush,
    output o_dbuf_din_acp, o_dbuf_dout, o_dbuf_dout_vld, o_dbuf_level,
           o_dbuf_word_pend, o_dbuf_word_done
  );
endinterface
`default_nettype wire

// File: rtl/idli_dout_buf_m.sv
`default_nettype none
// ============================================================================
//  Module      : idli_dout_buf_m
//  Description : Nibble-wide FIFO between the core data-output handshake and
//                the chip output pins, with word framing (WORD_NIBS nibbles,
//                LSB nibble first) tracked on both push and pop sides.
//                Optional macro IDLI_DBUF_BYPASS_EN: zero-latency bypass of
//                an empty buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module idli_dout_buf_m #(
  parameter int DEPTH     = 8,
  parameter int WORD_NIBS = 4
) (
  input  logic               i_dbuf_gck,
  input  logic               i_dbuf_rst,
  idli_dout_buf_m_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = $clog2(WORD_NIBS);
  localparam logic [LW-1:0] C_FULL = LW'(DEPTH);
  localparam logic [FW-1:0] C_LAST = FW'(WORD_NIBS - 1);

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [LW-1:0] r_level;
  logic [FW-1:0] r_push_ctr;
  logic [FW-1:0] r_pop_ctr;
  logic          r_word_done;

  logic          w_acp;
  logic          w_vld;
  logic [3:0]    w_dout;
  logic          w_push;
  logic          w_pop;
  logic          w_byp_take;
  logic          w_wr;
  logic          w_rd;

  // Accept depends only on stored level, flush and reset, never on the pin
  // side accept, so a full buffer refuses even when a pop happens that cycle.
  assign w_acp = (r_level != C_FULL) & ~bus.i_dbuf_flush & ~i_dbuf_rst;

`ifdef IDLI_DBUF_BYPASS_EN
  logic w_byp;
  // An empty buffer forwards the core nibble straight to the pins.
  assign w_byp      = (r_level == '0) & bus.i_dbuf_din_vld & ~bus.i_dbuf_flush & ~i_dbuf_rst;
  assign w_vld      = (r_level != '0) | w_byp;
  assign w_dout     = w_byp ? bus.i_dbuf_din : r_mem[r_rd_ptr];
  assign w_byp_take = w_byp & bus.i_dbuf_dout_acp;
`else
  assign w_vld      = (r_level != '0);
  assign w_dout     = r_mem[r_rd_ptr];
  assign w_byp_take = 1'b0;
`endif

  assign w_push = bus.i_dbuf_din_vld & w_acp;
  assign w_pop  = w_vld & bus.i_dbuf_dout_acp;
  // A bypassed nibble counts as pushed and popped but never touches storage.
  assign w_wr   = w_push & ~w_byp_take;
  assign w_rd   = w_pop & ~w_byp_take;

  assign bus.o_dbuf_din_acp   = w_acp;
  assign bus.o_dbuf_dout      = w_dout;
  assign bus.o_dbuf_dout_vld  = w_vld;
  assign bus.o_dbuf_level     = r_level;
  assign bus.o_dbuf_word_pend = (r_push_ctr != '0);
  assign bus.o_dbuf_word_done = r_word_done;

  // Storage array: written on a stored push, no reset needed on contents.
  always_ff @(posedge i_dbuf_gck) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= bus.i_dbuf_din;
    end
  end

  // Pointers and level; flush returns everything to empty.
  always_ff @(posedge i_dbuf_gck or posedge i_dbuf_rst) begin
    if (i_dbuf_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else if (bus.i_dbuf_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr & ~w_rd) begin
        r_level <= r_level + LW'(1);
      end else if (w_rd & ~w_wr) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  // Word framing: push/pop nibble counters and the word-drained pulse.
  always_ff @(posedge i_dbuf_gck or posedge i_dbuf_rst) begin
    if (i_dbuf_rst) begin
      r_push_ctr  <= '0;
      r_pop_ctr   <= '0;
      r_word_done <= 1'b0;
    end else if (bus.i_dbuf_flush) begin
      r_push_ctr  <= '0;
      r_pop_ctr   <= '0;
      r_word_done <= 1'b0;
    end else begin
      if (w_push) begin
        r_push_ctr <= r_push_ctr + FW'(1);
      end
      if (w_pop) begin
        r_pop_ctr <= r_pop_ctr + FW'(1);
      end
      r_word_done <= w_pop & (r_pop_ctr == C_LAST);
    end
  end

endmodule
`default_nettype wire

// File: doc/idli_dout_buf_m.md
Name: idli_dout_buf_m

Overview:
- Nibble-wide output buffer directly downstream of the core's data-output port.
- Accepts 4-bit nibbles from the core's dout/dout_vld/dout_acp handshake and stores them in a small FIFO.
- Presents them to the chip-level output pins through a second valid/accept handshake.
- Tracks 16-bit word framing (4 nibbles, LSB nibble first) so the system can tell when whole words have drained.

Parameters:
DEPTH, 8, FIFO depth in nibbles; power of two, >= 2.
WORD_NIBS, 4, nibbles per word for framing counters; power of two, >= 2.

Ports:
i_dbuf_gck  input  1  clock; all state on rising edge.
i_dbuf_rst  input  1  reset, asynchronous, active-high.
i_dbuf_din  input  4  nibble from core (core o_core_dout).
i_dbuf_din_vld  input  1  core nibble valid (core o_core_dout_vld).
o_dbuf_din_acp  output  1  buffer accepts nibble (to core i_core_dout_acp).
o_dbuf_dout  output  4  nibble to pins.
o_dbuf_dout_vld  output  1  pin-side nibble valid.
i_dbuf_dout_acp  input  1  pin side accepts nibble.
i_dbuf_flush  input  1  synchronous flush of contents and framing state.
o_dbuf_level  output  $clog2(DEPTH)+1  nibbles currently stored.
o_dbuf_word_pend  output  1  partial word pushed (push framing counter != 0).
o_dbuf_word_done  output  1  one-cycle pulse, cycle after last nibble of a word popped.

Behaviour:
- Clock and reset: one clock i_dbuf_gck; reset i_dbuf_rst is asynchronous, active-high.
- Reset (async assert, sync-clean deassert):
  - rd_ptr, wr_ptr, level, push/pop framing counters = 0.
  - o_dbuf_dout_vld = 0, o_dbuf_word_pend = 0, o_dbuf_word_done = 0.
  - o_dbuf_din_acp = 0 while reset is high; first possible accept is the first edge after deassert.
- Push: occurs when i_dbuf_din_vld & o_dbuf_din_acp at a rising edge.
  - Writes mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
- Pop: occurs when o_dbuf_dout_vld & i_dbuf_dout_acp. rd_ptr wraps modulo DEPTH.
- o_dbuf_din_acp = (level != DEPTH) & ~i_dbuf_flush & ~i_dbuf_rst.
  - Must not depend combinationally on i_dbuf_dout_acp.
  - Full + simultaneous pop still refuses the push that cycle.
- o_dbuf_dout = mem[rd_ptr]; o_dbuf_dout_vld = (level != 0).
  - Push-to-valid latency 1 cycle.
  - Nibble order strictly FIFO.
- Data held stable: while o_dbuf_dout_vld=1 and not popped, o_dbuf_dout holds its value.
- Level update: +1 on push only, -1 on pop only, unchanged on both or neither. Range 0..DEPTH inclusive.
- Empty: no pop is possible; dout value is don't-care.
- Framing counters ($clog2(WORD_NIBS) bits, wrap):
  - push_ctr increments on push; pop_ctr increments on pop.
  - o_dbuf_word_pend = (push_ctr != 0), combinational from the register.
  - o_dbuf_word_done is registered: set for exactly one cycle after a pop with pop_ctr == WORD_NIBS-1, else 0.
- Flush (i_dbuf_flush=1 at an edge):
  - Pointers, level and both framing counters return to 0; word_done cleared.
  - Any push presented that cycle is discarded (acp is 0).
  - A pop handshake in the same cycle is ignored: no word_done.
  - Flush dominates all other events.
- Reset mid-transfer: contents lost; pin side sees vld drop asynchronously with reset.

Optional Feature:
- Macro: IDLI_DBUF_BYPASS_EN.
- Defined: when level == 0, i_dbuf_din_vld=1 and not flushing:
  - o_dbuf_dout = i_dbuf_din and o_dbuf_dout_vld = 1 in the same cycle.
  - If i_dbuf_dout_acp=1, the nibble is consumed with no write; level stays 0; push_ctr and pop_ctr both advance.
  - If i_dbuf_dout_acp=0, a normal push occurs.
  - Zero-cycle latency through an empty buffer.
- Undefined: no combinational path from i_dbuf_din to o_dbuf_dout; minimum latency 1 cycle.

Test Plan:
- Reset then fill: push 0x1..0x8 with dout_acp=0.
  - acp high for 8 pushes, then 0; level=8.
  - Ninth nibble 0x9 held by core until a pop, then accepted.
- Drain: from full, hold dout_acp=1.
  - Pins see 0x1,0x2,...,0x8 on consecutive cycles.
  - word_done pulses one cycle after 0x4 and after 0x8 popped; level reaches 0; vld drops.
- Streaming: continuous vld on both sides, DEPTH=8, 100 random nibbles.
  - Output sequence identical to input.
  - Level stays at 1 steady state (0 with BYPASS_EN).
- Framing: push 0xA,0xB only.
  - word_pend=1, level=2.
  - Pop both: no word_done.
  - Push 2 more and pop them: word_done pulses once; word_pend=0.
- Flush: push 5 nibbles, assert flush for one cycle together with din_vld and dout_acp.
  - Next cycle: level=0, vld=0, word_pend=0, word_done=0.
  - Next pushed nibble 0xC is the first popped.
- Async reset mid-stream: assert rst between edges with level=3.
  - vld, level, acp go 0 immediately.
  - After deassert, acp=1 on first edge and FIFO is empty.
